ccr_branch_ctrl: RTL and testbench
==================================

# ccr_branch_ctrl

Condition-code register and branch resolver that consumes the ALU's {Negative, Carry, Zero} flags. It holds the architectural CCR, applies per-bit flag writes from the execute stage, and saves/restores the CCR around interrupts. It also evaluates conditional jumps (JZ/JN/JC) and unconditional JMP. On a taken branch it drives a registered PC redirect plus a multi-cycle pipeline flush back to fetch/decode.

## Interface
Parameters:
- ADDR_W, 16, width of branch target / PC redirect
- FLUSH_CYCLES, 2, cycles `flush` stays high after a taken branch (legal 1..7)

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- alu_flag  in  3  {N, C, Z} from ALU, same bit order as CCR
- flag_we  in  3  per-bit write enable for alu_flag (bit 2 = N, 1 = C, 0 = Z)
- br_valid  in  1  branch instruction present this cycle
- br_cond  in  2  00 JZ, 01 JN, 10 JC, 11 JMP
- br_target  in  ADDR_W  jump destination
- int_req  in  1  interrupt accepted: save CCR to shadow
- rti  in  1  return from interrupt: restore CCR from shadow
- ccr  out  3  architectural {N, C, Z}
- br_taken  out  1  one-cycle pulse, branch taken
- pc_sel  out  1  select pc_target at fetch (equals br_taken)
- pc_target  out  ADDR_W  registered redirect address
- flush  out  1  squash younger instructions in IF/ID

## Operation
- Effective flags: eff[i] = flag_we[i] ? alu_flag[i] : ccr[i].
- Tested bit: Z for JZ, N for JN, C for JC. Taken = br_valid & state==IDLE & (br_cond==11 | eff[tested]).
- CCR next value, priority high→low:
  - rst: 000.
  - rti with shadow_valid: ccr ← shadow; shadow_valid ← 0; flag_we and branch clear ignored that cycle.
  - Otherwise per bit: a taken JZ/JN/JC clears its tested bit. Clear beats alu write of the same bit. Other bits take eff. JMP does not modify flags.
- Shadow:
  - int_req: shadow ← eff (pre-clear), shadow_valid ← 1.
  - One-deep only; a second int_req overwrites the shadow.
  - int_req and rti in the same cycle: int_req wins, rti is ignored.
  - rti with shadow_valid=0 leaves ccr unchanged (flag_we still applies).
- FSM:
  - IDLE → FLUSH on taken; loads cnt ← FLUSH_CYCLES-1.
  - FLUSH: cnt decrements each cycle; FLUSH → IDLE when cnt==0.
  - br_valid is ignored in FLUSH (wrong-path instruction).
  - flag_we, int_req and rti remain active in FLUSH.
- pc_target is loaded only on taken and holds its value otherwise.

## Timing
- Reset values: ccr=000, br_taken=0, pc_sel=0, pc_target=0, flush=0, state=IDLE, cnt=0, shadow=000, shadow_valid=0. Reset mid-FLUSH drops flush immediately.
- Branch evaluated combinationally in cycle t; br_taken/pc_sel/pc_target valid cycle t+1 for exactly one cycle.
- flush is high cycles t+1 .. t+FLUSH_CYCLES, then low.
- ccr reflects writes/clears/restore at the edge ending cycle t (visible cycle t+1).
- Earliest next accepted branch: cycle t+FLUSH_CYCLES+1.

## Configuration
- BRANCH_FWD_EN defined: branch condition uses eff, forwarding same-cycle ALU flag writes.
- Undefined: branch condition uses registered ccr only. CCR update, clear priority and shadow behaviour are unchanged.

## Test plan
- Reset, then flag_we=111, alu_flag=101 → next cycle ccr=101; br_valid, br_cond=00 (JZ), br_target=0x0040 → next cycle br_taken=1, pc_target=0x0040, ccr=100; flush high 2 cycles.
- ccr=000, same cycle flag_we=001, alu_flag=001, JZ → with BRANCH_FWD_EN: taken, ccr stays 000. Without it: not taken, ccr=001.
- JMP to 0x1234 with ccr=011 → taken, ccr stays 011. A second br_valid in the following cycle (in FLUSH) → ignored, no br_taken.
- ccr=110, int_req → shadow=110. flag_we=111, alu_flag=000 → ccr=000. rti → ccr=110. Second rti → ccr unchanged.
- Same cycle: taken JC, flag_we=010, alu_flag=010 → ccr C=0. int_req in the same cycle → shadow C=1.
- FLUSH_CYCLES=3: taken branch, rst asserted during 2nd flush cycle → flush=0, br_taken=0, ccr=000 immediately. After rst release a branch is accepted on the first cycle.

Source files
------------

// File: rtl/ccr_branch_ctrl.sv
// ---------------------------------------------------------------------------
// ccr_branch_ctrl
//   Condition-code register {N, C, Z} with per-bit ALU writes, a one-deep
//   interrupt shadow, and a branch resolver for JZ/JN/JC/JMP. A taken branch
//   produces a registered one-cycle redirect (br_taken_o/pc_sel_o/pc_target_o)
//   and holds flush_o high for FLUSH_CYCLES cycles.
//
// Optional feature macro: BRANCH_FWD_EN
//   defined   : the branch condition sees same-cycle ALU flag writes
//   undefined : the branch condition sees the registered CCR only
//
// Parameters:
//   ADDR_W       width of branch target / PC redirect
//   FLUSH_CYCLES cycles flush_o stays high after a taken branch (1..7)
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   alu_flag_i   {N, C, Z} from the ALU
//   flag_we_i    per-bit write enable for alu_flag_i
//   br_valid_i   branch instruction present
//   br_cond_i    00 JZ, 01 JN, 10 JC, 11 JMP
//   br_target_i  jump destination
//   int_req_i    interrupt accepted: save CCR to shadow
//   rti_i        return from interrupt: restore CCR from shadow
//   ccr_o        architectural {N, C, Z}
//   br_taken_o   one-cycle taken pulse
//   pc_sel_o     fetch redirect select (same as br_taken_o)
//   pc_target_o  registered redirect address
//   flush_o      squash younger instructions in IF/ID
// ---------------------------------------------------------------------------
module ccr_branch_ctrl #(
  parameter int ADDR_W       = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [2:0]        alu_flag_i,
  input  logic [2:0]        flag_we_i,
  input  logic              br_valid_i,
  input  logic [1:0]        br_cond_i,
  input  logic [ADDR_W-1:0] br_target_i,
  input  logic              int_req_i,
  input  logic              rti_i,
  output logic [2:0]        ccr_o,
  output logic              br_taken_o,
  output logic              pc_sel_o,
  output logic [ADDR_W-1:0] pc_target_o,
  output logic              flush_o
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // Counter starts one below the flush length: the loading cycle is the first flush cycle.
  localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [2:0]          ccr_q, ccr_d;
  logic [2:0]          shadow_q, shadow_d;
  logic                shadow_valid_q, shadow_valid_d;
  logic                br_taken_q, br_taken_d;
  logic [ADDR_W-1:0]   pc_target_q, pc_target_d;
  logic                flush_q, flush_d;

  logic [2:0]          eff_s;
  logic [2:0]          cond_src_s;
  logic [2:0]          clr_mask_s;
  logic                cond_true_s;
  logic                taken_s;
  logic                restore_s;

  // Effective flags, branch condition evaluation and taken decision.
  always_comb begin
    eff_s       = (flag_we_i & alu_flag_i) | (~flag_we_i & ccr_q);
`ifdef BRANCH_FWD_EN
    cond_src_s  = eff_s;
`else
    cond_src_s  = ccr_q;
`endif
    cond_true_s = 1'b0;
    clr_mask_s  = 3'b000;
    case (br_cond_i)
      2'b00: begin
        cond_true_s = cond_src_s[0];
        clr_mask_s  = 3'b001;
      end
      2'b01: begin
        cond_true_s = cond_src_s[2];
        clr_mask_s  = 3'b100;
      end
      2'b10: begin
        cond_true_s = cond_src_s[1];
        clr_mask_s  = 3'b010;
      end
      2'b11: begin
        cond_true_s = 1'b1;
        clr_mask_s  = 3'b000;
      end
      default: begin
        cond_true_s = 1'b0;
        clr_mask_s  = 3'b000;
      end
    endcase
    taken_s   = br_valid_i & (state_q == ST_IDLE) & cond_true_s;
    // A simultaneous int_req takes priority, so the restore is suppressed.
    restore_s = rti_i & shadow_valid_q & ~int_req_i;
  end

  // CCR and shadow next-state.
  always_comb begin
    ccr_d          = ccr_q;
    shadow_d       = shadow_q;
    shadow_valid_d = shadow_valid_q;
    if (restore_s) begin
      ccr_d = shadow_q;
    end else if (taken_s) begin
      // Clearing the tested bit overrides an ALU write to that same bit.
      ccr_d = eff_s & ~clr_mask_s;
    end else begin
      ccr_d = eff_s;
    end
    if (int_req_i) begin
      // Shadow captures the flags before any branch clear.
      shadow_d       = eff_s;
      shadow_valid_d = 1'b1;
    end else if (restore_s) begin
      shadow_valid_d = 1'b0;
    end else begin
      shadow_valid_d = shadow_valid_q;
    end
  end

  // Flush FSM next-state and redirect outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_target_d = pc_target_q;
    case (state_q)
      ST_IDLE: begin
        if (taken_s) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = cnt_q;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end else begin
          state_d = ST_FLUSH;
          cnt_d   = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
    if (taken_s) begin
      pc_target_d = br_target_i;
    end else begin
      pc_target_d = pc_target_q;
    end
    br_taken_d = taken_s;
    flush_d    = (state_d == ST_FLUSH);
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      cnt_q          <= 3'd0;
      ccr_q          <= 3'b000;
      shadow_q       <= 3'b000;
      shadow_valid_q <= 1'b0;
      br_taken_q     <= 1'b0;
      pc_target_q    <= '0;
      flush_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      ccr_q          <= ccr_d;
      shadow_q       <= shadow_d;
      shadow_valid_q <= shadow_valid_d;
      br_taken_q     <= br_taken_d;
      pc_target_q    <= pc_target_d;
      flush_q        <= flush_d;
    end
  end

  assign ccr_o       = ccr_q;
  assign br_taken_o  = br_taken_q;
  assign pc_sel_o    = br_taken_q;
  assign pc_target_o = pc_target_q;
  assign flush_o     = flush_q;

endmodule

// File: tb/tb_ccr_branch_ctrl.sv
module tb_ccr_branch_ctrl;

`ifdef BRANCH_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  alu_flag, flag_we;
  logic        br_valid;
  logic [1:0]  br_cond;
  logic [15:0] br_target;
  logic        int_req, rti;

  logic [2:0]  ccr, ccr3;
  logic        br_taken, pc_sel, flush, br_taken3, pc_sel3, flush3;
  logic [15:0] pc_target, pc_target3;

  typedef struct {
    logic [2:0]  we;
    logic [2:0]  af;
    logic        bv;
    logic [1:0]  bc;
    logic [15:0] tgt;
    logic        ir;
    logic        rti;
    logic [2:0]  e_ccr;
    logic        e_tk;
    logic [15:0] e_tgt;
    logic        e_fl;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  ccr_branch_ctrl #(.ADDR_W(16), .FLUSH_CYCLES(2)) u_dut (
    .clk_i(clk), .rst_i(rst), .alu_flag_i(alu_flag), .flag_we_i(flag_we),
    .br_valid_i(br_valid), .br_cond_i(br_cond), .br_target_i(br_target),
    .int_req_i(int_req), .rti_i(rti), .ccr_o(ccr), .br_taken_o(br_taken),
    .pc_sel_o(pc_sel), .pc_target_o(pc_target), .flush_o(flush)
  );

  ccr_branch_ctrl #(.ADDR_W(16), .FLUSH_CYCLES(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .alu_flag_i(alu_flag), .flag_we_i(flag_we),
    .br_valid_i(br_valid), .br_cond_i(br_cond), .br_target_i(br_target),
    .int_req_i(int_req), .rti_i(rti), .ccr_o(ccr3), .br_taken_o(br_taken3),
    .pc_sel_o(pc_sel3), .pc_target_o(pc_target3), .flush_o(flush3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] we, input logic [2:0] af, input logic bv, input logic [1:0] bc,
                     input logic [15:0] tgt, input logic ir, input logic rt, input logic [2:0] e_ccr,
                     input logic e_tk, input logic [15:0] e_tgt, input logic e_fl);
    vec_t v;
    v.we = we; v.af = af; v.bv = bv; v.bc = bc; v.tgt = tgt; v.ir = ir; v.rti = rt;
    v.e_ccr = e_ccr; v.e_tk = e_tk; v.e_tgt = e_tgt; v.e_fl = e_fl;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    flag_we = v.we; alu_flag = v.af; br_valid = v.bv; br_cond = v.bc;
    br_target = v.tgt; int_req = v.ir; rti = v.rti;
  endtask

  task automatic idle();
    flag_we = 3'b000; alu_flag = 3'b000; br_valid = 1'b0; br_cond = 2'b00;
    br_target = 16'h0000; int_req = 1'b0; rti = 1'b0;
  endtask

  task automatic check_main(input vec_t e, input int idx);
    chk("ccr", idx, {29'd0, ccr}, {29'd0, e.e_ccr});
    chk("br_taken", idx, {31'd0, br_taken}, {31'd0, e.e_tk});
    chk("pc_sel", idx, {31'd0, pc_sel}, {31'd0, e.e_tk});
    chk("pc_target", idx, {16'd0, pc_target}, {16'd0, e.e_tgt});
    chk("flush", idx, {31'd0, flush}, {31'd0, e.e_fl});
  endtask

  initial begin
    vec_t e;
    // we    af    bv    bc     tgt       ir    rti   ccr   tk    tgt       fl
    add(3'b111, 3'b101, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0, 3'b101, 1'b0, 16'h0000, 1'b0);
    add(3'b000, 3'b000, 1'b1, 2'b00, 16'h0040, 1'b0, 1'b0, 3'b100, 1'b1, 16'h0040, 1'b1);
    add(3'b000, 3'b000, 1'b1, 2'b11, 16'hBEEF, 1'b0, 1'b0, 3'b100, 1'b0, 16'h0040, 1'b1);
    add(3'b000, 3'b000, 1'b1, 2'b11, 16'hBEEF, 1'b0, 1'b0, 3'b100, 1'b0, 16'h0040, 1'b0);
    add(3'b000, 3'b000, 1'b1, 2'b01, 16'h0100, 1'b0, 1'b0, 3'b000, 1'b1, 16'h0100, 1'b1);
    add(3'b000, 3'b000, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0, 3'b000, 1'b0, 16'h0100, 1'b1);
    add(3'b000, 3'b000, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0, 3'b000, 1'b0, 16'h0100, 1'b0);
    // Same-cycle Z write followed by JZ: forwarding decides the outcome.
    add(3'b001, 3'b001, 1'b1, 2'b00, 16'h0200, 1'b0, 1'b0, FWD ? 3'b000 : 3'b001, FWD,
        FWD ? 16'h0200 : 16'h0100, FWD);
    add(3'b000, 3'b000, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0, FWD ? 3'b000 : 3'b001, 1'b0,
        FWD ? 16'h0200 : 16'h0100, FWD);
    add(3'b000, 3'b000, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0, FWD ? 3'b000 : 3'b001, 1'b0,
        FWD ? 16'h0200 : 16'h0100, 1'b0);
    add(3'b111, 3'b011, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0, 3'b011, 1'b0,
        FWD ? 16'h0200 : 16'h0100, 1'b0);
    add(3'b000, 3'b000, 1'b1, 2'b11, 16'h1234, 1'b0, 1'b0, 3'b011, 1'b1, 16'h1234, 1'b1);
    add(3'b000, 3'b000, 1'b1, 2'b11, 16'h5555, 1'b0, 1'b0, 3'b011, 1'b0, 16'h1234, 1'b1);
    add(3'b000, 3'b000, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0, 3'b011, 1'b0, 16'h1234, 1'b0);
    // Interrupt save / restore.
    add(3'b111, 3'b110, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0, 3'b110, 1'b0, 16'h1234, 1'b0);
    add(3'b000, 3'b000, 1'b0, 2'b00, 16'h0000, 1'b1, 1'b0, 3'b110, 1'b0, 16'h1234, 1'b0);
    add(3'b111, 3'b000, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0, 3'b000, 1'b0, 16'h1234, 1'b0);
    add(3'b000, 3'b000, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b1, 3'b110, 1'b0, 16'h1234, 1'b0);
    add(3'b000, 3'b000, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b1, 3'b110, 1'b0, 16'h1234, 1'b0);
    add(3'b001, 3'b001, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b1, 3'b111, 1'b0, 16'h1234, 1'b0);
    // Taken JC + C write + int_req together: ccr C cleared, shadow keeps C=1.
    add(3'b010, 3'b010, 1'b1, 2'b10, 16'h0ABC, 1'b1, 1'b0, 3'b101, 1'b1, 16'h0ABC, 1'b1);
    add(3'b000, 3'b000, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0, 3'b101, 1'b0, 16'h0ABC, 1'b1);
    add(3'b000, 3'b000, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b1, 3'b111, 1'b0, 16'h0ABC, 1'b0);
    // int_req and rti in the same cycle: int_req wins.
    add(3'b000, 3'b000, 1'b0, 2'b00, 16'h0000, 1'b1, 1'b0, 3'b111, 1'b0, 16'h0ABC, 1'b0);
    add(3'b111, 3'b000, 1'b0, 2'b00, 16'h0000, 1'b1, 1'b1, 3'b000, 1'b0, 16'h0ABC, 1'b0);
    add(3'b111, 3'b011, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0, 3'b011, 1'b0, 16'h0ABC, 1'b0);
    add(3'b000, 3'b000, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b1, 3'b000, 1'b0, 16'h0ABC, 1'b0);
    // JC not taken with C=0.
    add(3'b000, 3'b000, 1'b1, 2'b10, 16'h0F0F, 1'b0, 1'b0, 3'b000, 1'b0, 16'h0ABC, 1'b0);

    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ccr", 0, {29'd0, ccr}, 32'd0);
    chk("rst_br_taken", 0, {31'd0, br_taken}, 32'd0);
    chk("rst_pc_sel", 0, {31'd0, pc_sel}, 32'd0);
    chk("rst_pc_target", 0, {16'd0, pc_target}, 32'd0);
    chk("rst_flush", 0, {31'd0, flush}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_main(e, i - 1);
      end
      drive(vecs[i]);
      sb.push_back(vecs[i]);
    end
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_main(e, vecs.size() - 1);
    end
    idle();

    // FLUSH_CYCLES=3 instance: reset during the second flush cycle.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    flag_we = 3'b111; alu_flag = 3'b111;
    br_valid = 1'b1; br_cond = 2'b11; br_target = 16'h0777;
    @(negedge clk);
    chk("f3_taken", 0, {31'd0, br_taken3}, 32'd1);
    chk("f3_pc_sel", 0, {31'd0, pc_sel3}, 32'd1);
    chk("f3_target", 0, {16'd0, pc_target3}, 32'h0777);
    chk("f3_flush1", 0, {31'd0, flush3}, 32'd1);
    chk("f3_ccr", 0, {29'd0, ccr3}, 32'd7);
    idle();
    @(negedge clk);
    chk("f3_flush2", 0, {31'd0, flush3}, 32'd1);
    chk("f3_taken2", 0, {31'd0, br_taken3}, 32'd0);
    rst = 1'b1;
    #1;
    chk("f3_rst_flush", 0, {31'd0, flush3}, 32'd0);
    chk("f3_rst_taken", 0, {31'd0, br_taken3}, 32'd0);
    chk("f3_rst_ccr", 0, {29'd0, ccr3}, 32'd0);
    chk("f3_rst_target", 0, {16'd0, pc_target3}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    br_valid = 1'b1; br_cond = 2'b11; br_target = 16'h0999;
    @(negedge clk);
    idle();
    chk("f3_post_taken", 0, {31'd0, br_taken3}, 32'd1);
    chk("f3_post_target", 0, {16'd0, pc_target3}, 32'h0999);
    chk("f3_post_fl1", 0, {31'd0, flush3}, 32'd1);
    @(negedge clk);
    chk("f3_post_fl2", 0, {31'd0, flush3}, 32'd1);
    chk("f3_post_pulse", 0, {31'd0, br_taken3}, 32'd0);
    @(negedge clk);
    chk("f3_post_fl3", 0, {31'd0, flush3}, 32'd1);
    @(negedge clk);
    chk("f3_post_fl4", 0, {31'd0, flush3}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
